// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared store-buffer entry layout for the queue, the drain stage and the cache pipeline.
package bsg_cache_sbuf_pkg;

  localparam int unsigned sbuf_addr_width_gp = 32;
  localparam int unsigned sbuf_data_width_gp = 32;
  localparam int unsigned sbuf_mask_width_gp = sbuf_data_width_gp / 8;

  // Entry packing is {addr, data, mask} with mask in the least significant bits.
  typedef struct packed {
    logic [sbuf_addr_width_gp-1:0] addr;
    logic [sbuf_data_width_gp-1:0] data;
    logic [sbuf_mask_width_gp-1:0] mask;
  } bsg_cache_sbuf_entry_s;

  // Flat entry width for non-default address/data widths.
  function automatic int unsigned sbuf_entry_width(input int unsigned addr_w,
                                                   input int unsigned data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/bsg_cache_sbuf_bypass_merge.sv
// Per-byte priority merge of pending stores (el0 newest, then el1, then hold reg) for load bypass.
module bsg_cache_sbuf_bypass_merge
  import bsg_cache_sbuf_pkg::*;
#(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
)(
  input  logic                                                     el0_v_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  el0_entry_i,
  input  logic                                                     el1_v_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  el1_entry_i,
  input  logic                                                     hold_v_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  hold_entry_i,
  input  logic [addr_width_p-1:0]                                  bypass_addr_i,
  output logic [data_width_p-1:0]                                  bypass_data_o,
  output logic [data_width_p/8-1:0]                                bypass_mask_o
);

  localparam int unsigned mask_width_lp  = data_width_p / 8;
  localparam int unsigned entry_width_lp = sbuf_entry_width(addr_width_p, data_width_p);
  localparam int unsigned lg_mask_lp     = $clog2(mask_width_lp);

  // Source index 0 = el0, 1 = el1, 2 = hold; lower index has higher priority.
  logic [entry_width_lp-1:0] src_entry [3];
  logic [2:0]                src_v;
  logic [addr_width_p-1:0]   src_addr  [3];
  logic [data_width_p-1:0]   src_data  [3];
  logic [mask_width_lp-1:0]  src_mask  [3];
  logic [2:0]                src_hit;

  assign src_entry[0] = el0_entry_i;
  assign src_entry[1] = el1_entry_i;
  assign src_entry[2] = hold_entry_i;
  assign src_v        = {hold_v_i, el1_v_i, el0_v_i};

  // Unpack fields and qualify each source by valid and word-address match.
  always_comb begin
    for (int unsigned s = 0; s < 3; s++) begin
      src_addr[s] = src_entry[s][entry_width_lp-1 -: addr_width_p];
      src_data[s] = src_entry[s][mask_width_lp +: data_width_p];
      src_mask[s] = src_entry[s][mask_width_lp-1:0];
      src_hit[s]  = src_v[s] & ((src_addr[s] >> lg_mask_lp) == (bypass_addr_i >> lg_mask_lp));
    end
  end

  // Per byte, take the newest contributing store; uncovered bytes read as zero.
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = '0;
    for (int unsigned b = 0; b < mask_width_lp; b++) begin
      if (src_hit[0] & src_mask[0][b]) begin
        bypass_data_o[8*b +: 8] = src_data[0][8*b +: 8];
        bypass_mask_o[b]        = 1'b1;
      end else if (src_hit[1] & src_mask[1][b]) begin
        bypass_data_o[8*b +: 8] = src_data[1][8*b +: 8];
        bypass_mask_o[b]        = 1'b1;
      end else if (src_hit[2] & src_mask[2][b]) begin
        bypass_data_o[8*b +: 8] = src_data[2][8*b +: 8];
        bypass_mask_o[b]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// Store-buffer drain: one-entry hold reg feeding masked data-mem writes, with read priority,
// starvation-forced writes and byte-merged bypass of all pending stores.
module bsg_cache_sbuf_drain
  import bsg_cache_sbuf_pkg::*;
#(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned max_stall_p  = 4
)(
  input  logic                                                     clk_i,
  input  logic                                                     reset_n_i,
  input  logic                                                     v_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  entry_i,
  output logic                                                     yumi_o,
  input  logic                                                     el0_v_i,
  input  logic                                                     el1_v_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  el0_snoop_i,
  input  logic [sbuf_entry_width(addr_width_p, data_width_p)-1:0]  el1_snoop_i,
  input  logic                                                     rd_v_i,
  output logic                                                     stall_o,
  output logic                                                     dmem_w_v_o,
  output logic [addr_width_p-1:0]                                  dmem_w_addr_o,
  output logic [data_width_p-1:0]                                  dmem_w_data_o,
  output logic [data_width_p/8-1:0]                                dmem_w_mask_o,
  input  logic [addr_width_p-1:0]                                  bypass_addr_i,
  output logic [data_width_p-1:0]                                  bypass_data_o,
  output logic [data_width_p/8-1:0]                                bypass_mask_o,
  output logic                                                     empty_o
);

  localparam int unsigned mask_width_lp  = data_width_p / 8;
  localparam int unsigned entry_width_lp = sbuf_entry_width(addr_width_p, data_width_p);
  localparam int unsigned cnt_width_lp   = $clog2(max_stall_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_stall_p);

  logic                      hold_v;
  logic [entry_width_lp-1:0] hold_entry;
  logic [cnt_width_lp-1:0]   stall_cnt;
  logic                      grant;

  // Handshakes are held off while reset is asserted so a held entry is dropped, never written.
  assign stall_o    = reset_n_i & hold_v & (stall_cnt == max_cnt_lp);
  assign grant      = reset_n_i & hold_v & (~rd_v_i | stall_o);
  assign yumi_o     = reset_n_i & v_i & (~hold_v | grant);
  assign dmem_w_v_o = grant;
  assign empty_o    = ~hold_v & ~v_i;

  assign dmem_w_addr_o = hold_entry[entry_width_lp-1 -: addr_width_p];
  assign dmem_w_data_o = hold_entry[mask_width_lp +: data_width_p];
  assign dmem_w_mask_o = hold_entry[mask_width_lp-1:0];

  // Hold valid and starvation counter: load on pop, clear on write, count denied cycles.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hold_v    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (yumi_o)
        hold_v <= 1'b1;
      else if (grant)
        hold_v <= 1'b0;

      if (grant | ~hold_v)
        stall_cnt <= '0;
      else if (rd_v_i & (stall_cnt != max_cnt_lp))
        stall_cnt <= stall_cnt + cnt_width_lp'(1);
    end
  end

  // Hold payload is qualified by hold_v and needs no reset.
  always_ff @(posedge clk_i) begin
    if (yumi_o)
      hold_entry <= entry_i;
  end

  bsg_cache_sbuf_bypass_merge #(
    .addr_width_p(addr_width_p),
    .data_width_p(data_width_p)
  ) merge (
    .el0_v_i       (el0_v_i),
    .el0_entry_i   (el0_snoop_i),
    .el1_v_i       (el1_v_i),
    .el1_entry_i   (el1_snoop_i),
    .hold_v_i      (hold_v),
    .hold_entry_i  (hold_entry),
    .bypass_addr_i (bypass_addr_i),
    .bypass_data_o (bypass_data_o),
    .bypass_mask_o (bypass_mask_o)
  );

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Directed + randomized bench for the store-buffer drain stage against a queue-based model.
module tb_bsg_cache_sbuf_drain;
  import bsg_cache_sbuf_pkg::*;

  localparam int unsigned MS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n_i = 1'b0;
  logic                  v_i = 1'b0;
  bsg_cache_sbuf_entry_s entry_i = '0;
  logic                  yumi_o;
  logic                  el0_v_i = 1'b0, el1_v_i = 1'b0;
  bsg_cache_sbuf_entry_s el0_snoop_i = '0, el1_snoop_i = '0;
  logic                  rd_v_i = 1'b0;
  logic                  stall_o, dmem_w_v_o, empty_o;
  logic [31:0]           dmem_w_addr_o, dmem_w_data_o, bypass_addr_i = '0, bypass_data_o;
  logic [3:0]            dmem_w_mask_o, bypass_mask_o;

  bsg_cache_sbuf_drain #(.addr_width_p(32), .data_width_p(32), .max_stall_p(MS)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .entry_i(entry_i), .yumi_o(yumi_o),
    .el0_v_i(el0_v_i), .el1_v_i(el1_v_i), .el0_snoop_i(el0_snoop_i), .el1_snoop_i(el1_snoop_i),
    .rd_v_i(rd_v_i), .stall_o(stall_o), .dmem_w_v_o(dmem_w_v_o), .dmem_w_addr_o(dmem_w_addr_o),
    .dmem_w_data_o(dmem_w_data_o), .dmem_w_mask_o(dmem_w_mask_o), .bypass_addr_i(bypass_addr_i),
    .bypass_data_o(bypass_data_o), .bypass_mask_o(bypass_mask_o), .empty_o(empty_o)
  );

  int checks = 0;
  int failures = 0;

  // Model: stores accepted but not yet written (at most one), and denied-cycle count.
  bsg_cache_sbuf_entry_s pending[$];
  int unsigned denied = 0;
  bit warm = 0;

  // Outputs captured at the most recent sample point.
  logic        o_yumi, o_wv, o_stall, o_empty;
  logic [31:0] o_waddr, o_bdata;
  logic [3:0]  o_bmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest store wins per byte: apply sources oldest first, letting later ones overwrite.
  function automatic void model_bypass(input bit hv, input bsg_cache_sbuf_entry_s h,
                                       output logic [31:0] d, output logic [3:0] m);
    bsg_cache_sbuf_entry_s src[3];
    bit sv[3];
    src[0] = h;           sv[0] = hv;
    src[1] = el1_snoop_i; sv[1] = el1_v_i;
    src[2] = el0_snoop_i; sv[2] = el0_v_i;
    d = '0;
    m = '0;
    for (int s = 0; s < 3; s++)
      if (sv[s] && (src[s].addr / 4 == bypass_addr_i / 4))
        for (int b = 0; b < 4; b++)
          if (src[s].mask[b]) begin
            d[8*b +: 8] = src[s].data[8*b +: 8];
            m[b] = 1'b1;
          end
  endfunction

  // One cycle: sample and check away from the edge, then advance the model at posedge.
  task automatic tick();
    bit hv, e_stall, e_grant, e_yumi;
    logic [31:0] ed;
    logic [3:0] em;
    bsg_cache_sbuf_entry_s h;
    #2;
    hv = (pending.size() != 0);
    h = hv ? pending[0] : '0;
    e_stall = reset_n_i && hv && (denied == MS);
    e_grant = reset_n_i && hv && (!rd_v_i || e_stall);
    e_yumi  = reset_n_i && v_i && (!hv || e_grant);
    o_yumi = yumi_o; o_wv = dmem_w_v_o; o_stall = stall_o; o_empty = empty_o;
    o_waddr = dmem_w_addr_o; o_bdata = bypass_data_o; o_bmask = bypass_mask_o;
    chk("yumi", 64'(yumi_o), 64'(e_yumi));
    chk("w_v", 64'(dmem_w_v_o), 64'(e_grant));
    chk("stall", 64'(stall_o), 64'(e_stall));
    if (warm) begin
      chk("empty", 64'(empty_o), 64'(!hv && !v_i));
      model_bypass(hv, h, ed, em);
      chk("bp_mask", 64'(bypass_mask_o), 64'(em));
      chk("bp_data", 64'(bypass_data_o), 64'(ed));
    end
    if (e_grant) begin
      chk("w_addr", 64'(dmem_w_addr_o), 64'(h.addr));
      chk("w_data", 64'(dmem_w_data_o), 64'(h.data));
      chk("w_mask", 64'(dmem_w_mask_o), 64'(h.mask));
    end
    @(posedge clk);
    if (!reset_n_i) begin
      pending.delete();
      denied = 0;
    end else begin
      if (!hv || e_grant) denied = 0;
      else if (rd_v_i && denied < MS) denied++;
      if (e_grant) void'(pending.pop_front());
      if (e_yumi) pending.push_back(entry_i);
    end
    warm = 1;
    @(negedge clk);
  endtask

  function automatic bsg_cache_sbuf_entry_s rand_entry();
    bsg_cache_sbuf_entry_s e;
    e.addr = 32'($urandom_range(0, 31));
    e.data = $urandom;
    e.mask = 4'($urandom_range(0, 15));
    return e;
  endfunction

  initial begin
    bit found;
    int unsigned lat;

    // Reset held two cycles with a valid head: nothing popped or written.
    reset_n_i = 1'b0; v_i = 1'b1; entry_i = rand_entry();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_yumi", 64'(o_yumi), 64'd0);
      chk("rst_w_v", 64'(o_wv), 64'd0);
    end

    // Back-to-back stores 0x0..0xC with no reads: pop each cycle, write one cycle later.
    reset_n_i = 1'b1; rd_v_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v_i = (k < 4);
      entry_i.addr = 32'(4 * k); entry_i.data = $urandom; entry_i.mask = 4'hF;
      tick();
      if (k < 4) chk("b2b_yumi", 64'(o_yumi), 64'd1);
      if (k >= 1) begin
        chk("b2b_w_v", 64'(o_wv), 64'd1);
        chk("b2b_w_addr", 64'(o_waddr), 64'(4 * (k - 1)));
      end
    end

    // Constant reads starve the hold reg: write is forced on the fifth cycle.
    v_i = 1'b1; rd_v_i = 1'b1; entry_i = rand_entry();
    tick();
    v_i = 1'b0;
    found = 0; lat = 0;
    for (int unsigned i = 1; i <= 10 && !found; i++) begin
      tick();
      if (o_wv) begin
        found = 1; lat = i;
        chk("forced_stall", 64'(o_stall), 64'd1);
      end
    end
    chk("stall_latency", 64'(lat), 64'(MS + 1));

    // Three-source byte merge on the same word.
    v_i = 1'b1; rd_v_i = 1'b1;
    entry_i.addr = 32'h10; entry_i.data = 32'h11223344; entry_i.mask = 4'b0011;
    tick();
    v_i = 1'b0;
    el1_v_i = 1'b1; el1_snoop_i.addr = 32'h10; el1_snoop_i.data = 32'hAABBCCDD; el1_snoop_i.mask = 4'b0110;
    el0_v_i = 1'b1; el0_snoop_i.addr = 32'h10; el0_snoop_i.data = 32'h55667788; el0_snoop_i.mask = 4'b1000;
    bypass_addr_i = 32'h12;
    tick();
    chk("bp_ex_mask", 64'(o_bmask), 64'hF);
    chk("bp_ex_data", 64'(o_bdata), 64'h55BBCC44);
    bypass_addr_i = 32'h20;
    tick();
    chk("bp_miss_mask", 64'(o_bmask), 64'd0);
    chk("bp_miss_data", 64'(o_bdata), 64'd0);

    // Reset while holding under read pressure: entry discarded, never written.
    el0_v_i = 1'b0; el1_v_i = 1'b0;
    reset_n_i = 1'b0;
    tick();
    chk("rst_hold_w_v", 64'(o_wv), 64'd0);
    reset_n_i = 1'b1;
    tick();
    chk("post_rst_w_v", 64'(o_wv), 64'd0);
    chk("post_rst_empty", 64'(o_empty), 64'd1);
    chk("post_rst_stall", 64'(o_stall), 64'd0);

    // Randomized traffic, read pressure and occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset_n_i = ($urandom_range(0, 39) != 0);
      v_i = $urandom_range(0, 1) != 0;
      rd_v_i = ($urandom_range(0, 9) < 6);
      entry_i = rand_entry();
      el0_v_i = $urandom_range(0, 1) != 0; el0_snoop_i = rand_entry();
      el1_v_i = $urandom_range(0, 1) != 0; el1_snoop_i = rand_entry();
      bypass_addr_i = 32'($urandom_range(0, 31));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
